// File: rtl/if_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// if_fetch_unit_if
// Instruction SRAM handshake between the fetch unit (master) and the
// instruction memory (slave).
//   inst_sram_req      master->slave  fetch request, held until accepted
//   inst_sram_addr     master->slave  word-aligned fetch address
//   inst_sram_addr_ok  slave->master  request accepted this cycle
//   inst_sram_data_ok  slave->master  read data valid this cycle
//   inst_sram_rdata    slave->master  fetched instruction word
// -----------------------------------------------------------------------------
interface if_fetch_unit_if;
    logic        inst_sram_req;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;

    modport master (
        output inst_sram_req,
        output inst_sram_addr,
        input  inst_sram_addr_ok,
        input  inst_sram_data_ok,
        input  inst_sram_rdata
    );

    modport slave (
        input  inst_sram_req,
        input  inst_sram_addr,
        output inst_sram_addr_ok,
        output inst_sram_data_ok,
        output inst_sram_rdata
    );
endinterface

// File: rtl/if_fetch_unit.sv
// -----------------------------------------------------------------------------
// if_fetch_unit
// Instruction fetch stage. Issues one SRAM read at a time, hands the returned
// word to ID together with its PC, and follows branch redirects from ID while
// always delivering the delay-slot instruction already in flight.
//   clk           rising-edge clock
//   rst           asynchronous active-low reset
//   stall[5:0]    pipeline stall vector; bit 1 set means ID cannot accept
//   br_bus        {br_e, br_addr[31:0]} redirect request from ID
//   sram          instruction SRAM handshake (master side)
//   if_to_id_bus  {ce, pc[31:0], inst[31:0]}, all-zero when no instruction
//   stallreq      IF has no instruction ready yet
// -----------------------------------------------------------------------------
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'hBFC0_0000,
    parameter int          IF_TO_ID_WD = 65,
    parameter int          BR_WD       = 33
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [5:0]             stall,
    input  logic [BR_WD-1:0]       br_bus,
    if_fetch_unit_if.master        sram,
    output logic [IF_TO_ID_WD-1:0] if_to_id_bus,
    output logic                   stallreq
);

    typedef enum logic [1:0] {
        ST_RST,
        ST_REQ,
        ST_WAIT,
        ST_HOLD
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] br_tgt_q, br_tgt_d;
    logic [31:0] inst_buf_q, inst_buf_d;
    logic        br_pend_q, br_pend_d;

    logic        br_e;
    logic [31:0] br_addr;
    logic        inst_valid;
    logic        fire;
    logic [31:0] inst;
    logic [31:0] next_pc;
    logic        unused_bits;

    // Low address bits of a redirect are meaningless for word fetches.
    assign br_e    = br_bus[BR_WD-1];
    assign br_addr = {br_bus[31:2], 2'b00};

    assign unused_bits = ^{stall[5:2], stall[0], br_bus[1:0]};

    // Data arriving in WAIT is usable in the same cycle; in HOLD it comes
    // from the buffer. A data_ok in any other state is stray and ignored.
    assign inst_valid = (state_q == ST_HOLD) ||
                        ((state_q == ST_WAIT) && sram.inst_sram_data_ok);
    assign fire       = inst_valid && !stall[1];
    assign inst       = (state_q == ST_HOLD) ? inst_buf_q : sram.inst_sram_rdata;

    // A redirect in the fire cycle itself wins over an older pending one.
    assign next_pc = br_e      ? br_addr  :
                     br_pend_q ? br_tgt_q :
                                 pc_q + 32'd4;

    always_comb begin
        // NOTE: every next-state value gets a hold default first so no path
        // through the case/if tree leaves a latch behind.
        state_d    = state_q;
        pc_d       = pc_q;
        br_tgt_d   = br_tgt_q;
        br_pend_d  = br_pend_q;
        inst_buf_d = inst_buf_q;

        case (state_q)
            ST_RST:  state_d = ST_REQ;
            ST_REQ:  if (sram.inst_sram_addr_ok) state_d = ST_WAIT;
            ST_WAIT: begin
                if (sram.inst_sram_data_ok) begin
                    if (fire) begin
                        state_d = ST_REQ;
                    end else begin
                        state_d    = ST_HOLD;
                        inst_buf_d = sram.inst_sram_rdata;
                    end
                end
            end
            ST_HOLD: if (fire) state_d = ST_REQ;
            default: state_d = ST_RST;
        endcase

        // Redirects never squash: the instruction in flight is the delay slot
        // and is delivered; only the PC after it is affected.
        if (fire) begin
            pc_d      = next_pc;
            br_pend_d = 1'b0;
        end else if (br_e) begin
            br_pend_d = 1'b1;
            br_tgt_d  = br_addr;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_RST;
            pc_q       <= {RESET_PC[31:2], 2'b00};
            br_tgt_q   <= '0;
            br_pend_q  <= 1'b0;
            // NOTE: inst_buf is a single word, not a memory array, so it is
            // cleared with the rest of the state for a clean post-reset view.
            inst_buf_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            br_tgt_q   <= br_tgt_d;
            br_pend_q  <= br_pend_d;
            inst_buf_q <= inst_buf_d;
        end
    end

    assign sram.inst_sram_req  = (state_q == ST_REQ);
    assign sram.inst_sram_addr = {pc_q[31:2], 2'b00};

    assign if_to_id_bus = inst_valid ? {1'b1, pc_q, inst} : '0;
    assign stallreq     = (state_q == ST_REQ) ||
                          ((state_q == ST_WAIT) && !sram.inst_sram_data_ok);

endmodule

// File: tb/tb_if_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_unit
// A driver process plays instruction memory and ID (stall / branch), a
// monitor process keeps a program-order model of the fetch stream and checks
// every DUT output each cycle against queued expectations.
// -----------------------------------------------------------------------------
module tb_if_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [5:0]  stall;
    logic [32:0] br_bus;
    logic [64:0] if_to_id_bus;
    logic        stallreq;

    if_fetch_unit_if sram ();

    if_fetch_unit #(
        .RESET_PC   (RESET_PC),
        .IF_TO_ID_WD(65),
        .BR_WD      (33)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .br_bus      (br_bus),
        .sram        (sram),
        .if_to_id_bus(if_to_id_bus),
        .stallreq    (stallreq)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int n_dlv    = 0;

    // Stimulus knobs, set by the sequence and read by the driver.
    int          acc_pct   = 100;
    int          lat_min   = 0;
    int          lat_max   = 0;
    int          stall_pct = 0;
    int          br_pct    = 0;
    int          spur_pct  = 0;
    bit          br_arm    = 1'b0;
    logic [31:0] br_arm_pc = '0;
    logic [31:0] br_arm_tgt = '0;
    bit          stall_arm = 1'b0;

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory contents: a fixed word at the reset vector, a scramble elsewhere.
    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a == 32'hBFC0_0000) return 32'h3C01_1234;
        return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
    endfunction

    // ---------------------------------------------------------------- driver
    initial begin : driver
        bit          outst = 1'b0;
        int          cnt = 0;
        logic [31:0] oaddr = '0;
        bit          br_next = 1'b0;
        logic [31:0] br_next_tgt = '0;
        int          stall_hold = 0;
        stall  = '0;
        br_bus = '0;
        sram.inst_sram_addr_ok = 1'b0;
        sram.inst_sram_data_ok = 1'b0;
        sram.inst_sram_rdata   = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                outst = 1'b0; br_next = 1'b0; stall_hold = 0;
                stall = '0; br_bus = '0;
                sram.inst_sram_addr_ok = 1'b0;
                sram.inst_sram_data_ok = 1'b0;
                sram.inst_sram_rdata   = '0;
            end else begin
                // ID side: branch from an armed trigger or at random.
                br_bus = '0;
                if (br_next) begin
                    br_bus  = {1'b1, br_next_tgt};
                    br_next = 1'b0;
                end else if ($urandom_range(99) < br_pct) begin
                    br_bus = {1'b1, 32'($urandom)};
                end
                // Memory read data.
                sram.inst_sram_data_ok = 1'b0;
                sram.inst_sram_rdata   = $urandom;
                if (outst) begin
                    if (cnt == 0) begin
                        sram.inst_sram_data_ok = 1'b1;
                        sram.inst_sram_rdata   = mem(oaddr);
                        outst = 1'b0;
                        if (stall_arm) begin
                            stall_arm  = 1'b0;
                            stall_hold = 4;
                        end
                    end else begin
                        cnt--;
                    end
                end else if ($urandom_range(99) < spur_pct) begin
                    sram.inst_sram_data_ok = 1'b1;
                end
                // Memory request acceptance.
                sram.inst_sram_addr_ok = 1'b0;
                if (sram.inst_sram_req && ($urandom_range(99) < acc_pct)) begin
                    sram.inst_sram_addr_ok = 1'b1;
                    outst = 1'b1;
                    oaddr = sram.inst_sram_addr;
                    cnt   = $urandom_range(lat_max, lat_min);
                    if (br_arm && oaddr == br_arm_pc) begin
                        br_arm      = 1'b0;
                        br_next     = 1'b1;
                        br_next_tgt = br_arm_tgt;
                    end
                end else if (!sram.inst_sram_req && ($urandom_range(99) < spur_pct)) begin
                    sram.inst_sram_addr_ok = 1'b1;
                end
                // Stall vector: only bit 1 matters, the rest is noise.
                stall = 6'($urandom);
                if (stall_hold > 0) begin
                    stall[1] = 1'b1;
                    stall_hold--;
                end else begin
                    stall[1] = ($urandom_range(99) < stall_pct);
                end
            end
        end
    end

    // --------------------------------------------------------------- monitor
    // Model: instructions are delivered in program order; after the one at P,
    // the next fetch is the latest redirect seen since the previous delivery
    // (up to and including the delivery cycle), otherwise P+4.
    initial begin : monitor
        logic [31:0] addr_q[$];
        logic [64:0] dlv_q[$];
        bit          started = 1'b0;
        bit          waiting = 1'b0;
        bit          have_data = 1'b0;
        bit          br_v = 1'b0;
        logic [31:0] br_t = '0;
        bit          exp_req, exp_valid, fire;
        logic [31:0] pc, nxt;
        forever begin
            @(negedge clk);
            #3;
            if (!rst) begin
                check("rst_req", 65'(sram.inst_sram_req), 65'd0);
                check("rst_bus", if_to_id_bus, 65'd0);
                check("rst_stallreq", 65'(stallreq), 65'd0);
                addr_q.delete();
                addr_q.push_back(RESET_PC);
                dlv_q.delete();
                started = 1'b0; waiting = 1'b0; have_data = 1'b0; br_v = 1'b0;
            end else begin
                exp_req   = started && (addr_q.size() > 0);
                exp_valid = have_data || (waiting && sram.inst_sram_data_ok);
                check("req", 65'(sram.inst_sram_req), 65'(exp_req));
                check("stallreq", 65'(stallreq),
                      65'(exp_req || (waiting && !sram.inst_sram_data_ok)));
                check("ce", 65'(if_to_id_bus[64]), 65'(exp_valid));
                if (exp_valid) check("bus", if_to_id_bus, dlv_q[0]);
                if (br_bus[32]) begin
                    br_v = 1'b1;
                    br_t = {br_bus[31:2], 2'b00};
                end
                fire = exp_valid && !stall[1];
                if (fire) begin
                    pc  = dlv_q[0][63:32];
                    nxt = br_v ? br_t : pc + 32'd4;
                    br_v = 1'b0;
                    void'(dlv_q.pop_front());
                    addr_q.push_back(nxt);
                    have_data = 1'b0;
                    n_dlv++;
                end else if (waiting && sram.inst_sram_data_ok) begin
                    have_data = 1'b1;
                end
                if (sram.inst_sram_data_ok) waiting = 1'b0;
                if (exp_req) begin
                    check("addr", 65'(sram.inst_sram_addr), 65'(addr_q[0]));
                    if (sram.inst_sram_addr_ok) begin
                        dlv_q.push_back({1'b1, addr_q[0], mem(addr_q[0])});
                        void'(addr_q.pop_front());
                        waiting = 1'b1;
                    end
                end
                started = 1'b1;
            end
        end
    end

    // -------------------------------------------------------------- sequence
    task automatic do_reset();
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        check("imm_rst_req", 65'(sram.inst_sram_req), 65'd0);
        check("imm_rst_bus", if_to_id_bus, 65'd0);
        check("imm_rst_stallreq", 65'(stallreq), 65'd0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic set_knobs(input int acc, input int lmin, input int lmax,
                             input int stp, input int brp, input int spp);
        acc_pct = acc; lat_min = lmin; lat_max = lmax;
        stall_pct = stp; br_pct = brp; spur_pct = spp;
    endtask

    initial begin : sequence_main
        set_knobs(100, 0, 0, 0, 0, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;

        // Back-to-back fetch from the reset vector, one cycle per handshake.
        repeat (12) @(negedge clk);
        check("stream_deliveries_ge3", 65'(n_dlv >= 3), 65'd1);

        // ID stall while an instruction is ready.
        stall_arm = 1'b1;
        repeat (15) @(negedge clk);
        check("stall_armed_used", 65'(stall_arm), 65'd0);

        // Redirect during WAIT: delay slot at BFC00010, then BFC00100.
        do_reset();
        set_knobs(100, 2, 2, 0, 0, 0);
        br_arm_pc = 32'hBFC0_0010; br_arm_tgt = 32'hBFC0_0100; br_arm = 1'b1;
        repeat (45) @(negedge clk);
        check("br_wait_triggered", 65'(br_arm), 65'd0);

        // Redirect coincident with fire, unaligned target.
        do_reset();
        set_knobs(100, 0, 0, 0, 0, 0);
        br_arm_pc = 32'hBFC0_0020; br_arm_tgt = 32'hBFC0_0043; br_arm = 1'b1;
        repeat (30) @(negedge clk);
        check("br_fire_triggered", 65'(br_arm), 65'd0);

        // Address wrap from FFFFFFFC to 00000000.
        do_reset();
        br_arm_pc = 32'hBFC0_0000; br_arm_tgt = 32'hFFFF_FFFC; br_arm = 1'b1;
        repeat (12) @(negedge clk);
        check("wrap_triggered", 65'(br_arm), 65'd0);

        // Reset pulse in the middle of a long WAIT.
        do_reset();
        set_knobs(100, 3, 3, 0, 0, 0);
        repeat (3) @(negedge clk);
        do_reset();
        repeat (12) @(negedge clk);

        // Randomized traffic.
        set_knobs(60, 0, 3, 30, 8, 10);
        repeat (3000) @(negedge clk);
        check("random_deliveries_ge100", 65'(n_dlv >= 100), 65'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'hBFC0_0000, address of the first instruction fetched after reset.
REQ-002 Parameter: IF_TO_ID_WD, 65, width of if_to_id_bus, packed as {ce, pc[31:0], inst[31:0]}.
REQ-003 Parameter: BR_WD, 33, width of br_bus, packed as {br_e, br_addr[31:0]}.
REQ-004 Clocking and reset: one clock; reset is asynchronous and active-low.
REQ-005 Port: clk  in  1  rising-edge clock.
REQ-006 Port: rst  in  1  asynchronous active-low reset.
REQ-007 Port: stall  in  6  pipeline stall vector; bit1=Stop means ID does not accept a new instruction.
REQ-008 Port: br_bus  in  BR_WD  redirect request from ID, valid while br_e=1.
REQ-009 Port: inst_sram_req  out  1  fetch request.
REQ-010 Port: inst_sram_addr  out  32  fetch address, word aligned.
REQ-011 Port: inst_sram_addr_ok  in  1  request accepted this cycle.
REQ-012 Port: inst_sram_data_ok  in  1  read data valid this cycle.
REQ-013 Port: inst_sram_rdata  in  32  fetched instruction.
REQ-014 Port: if_to_id_bus  out  IF_TO_ID_WD  instruction handed to ID.
REQ-015 Port: stallreq  out  1  IF requests a pipeline stall because an instruction is not yet available.

Function
REQ-016 The FSM SHALL have four states: RST, REQ, WAIT, HOLD.
- RST->REQ: unconditional, the first clock after reset release.
- REQ: req=1 and addr=pc_reg; addr_ok -> WAIT.
- WAIT: data_ok with no fire -> HOLD, capturing rdata into inst_buf.
- HOLD: fire -> REQ.
REQ-017 Fire SHALL be defined as inst_valid & (stall[1]==0), where inst_valid = (state==HOLD) | (state==WAIT & data_ok).
REQ-018 When data_ok and fire occur together in WAIT, rdata SHALL pass straight to if_to_id_bus and the FSM SHALL go directly to REQ, so HOLD is bypassed.
REQ-019 if_to_id_bus SHALL be {1, pc_reg, inst} while inst_valid=1, and all-zero otherwise.
- inst = rdata in WAIT.
- inst = inst_buf in HOLD.
REQ-020 On fire, pc_reg SHALL load next_pc:
- br_e=1 this cycle: br_addr.
- otherwise br_pend=1: br_tgt.
- otherwise: pc_reg+4, wrapping modulo 2^32.
REQ-021 br_e=1 in a non-fire cycle SHALL set br_pend=1 and br_tgt=br_addr.
- A repeated br_e SHALL overwrite br_tgt.
- Fire SHALL clear br_pend.
REQ-022 The instruction in flight when br_e arrives is the delay slot; it SHALL be delivered, never squashed.
REQ-023 pc_reg[1:0] and inst_sram_addr[1:0] SHALL always be 2'b00; br_addr[1:0] SHALL be ignored.
REQ-024 inst_sram_req SHALL be 1 only in REQ; a request with addr_ok=0 SHALL hold addr stable until accepted.
REQ-025 At most one request SHALL be outstanding; no new request SHALL be issued before the previous data_ok.
REQ-026 stallreq SHALL be 1 in REQ and WAIT when data_ok=0, and 0 otherwise.
REQ-027 A data_ok outside WAIT SHALL be ignored.
REQ-028 If stall[1]=1 persists, HOLD SHALL keep if_to_id_bus constant indefinitely.

Reset
REQ-029 While rst=0, the block SHALL hold these values regardless of clk:
- state=RST, pc_reg=RESET_PC.
- br_pend=0, br_tgt=0, inst_buf=0.
- inst_sram_req=0, if_to_id_bus=0, stallreq=0.
REQ-030 rst asserted mid-fetch SHALL abandon the fetch; after release, fetching SHALL restart at RESET_PC with branch state cleared.

Verification
REQ-031 Reset release, addr_ok and data_ok one cycle after each request, stall=0:
- Required: addr sequence BFC00000, BFC00004, BFC00008.
- Required: each instruction appears on the bus for exactly one cycle with ce=1.
REQ-032 Zero-latency fire: data_ok=1 with rdata=32'h3C01_1234 while stall[1]=0:
- Required: bus={1,BFC00000,3C011234} in that same cycle.
- Required: REQ for BFC00004 in the next cycle.
REQ-033 ID stall: data arrives, then stall[1]=1 for 3 cycles:
- Required: HOLD with an identical bus for 3 cycles.
- Required: no req during the stall.
- Required: the next addr is pc+4 after stall[1] drops.
REQ-034 Branch during WAIT at pc=BFC00010: one-cycle br_bus={1,BFC00100}:
- Required: the delay slot at BFC00010 is delivered.
- Required: the next request addr is BFC00100.
REQ-035 Branch coincident with fire at pc=BFC00020, br_addr=BFC00043:
- Required: next addr BFC00040.
- Required: br_pend stays 0.
REQ-036 Wrap and reset:
- Fire at pc=FFFFFFFC: required next addr 00000000.
- rst=0 pulse during WAIT: required outputs zero immediately and a restart at BFC00000.
